// File: rtl/ad7528_atten_sequencer.sv
// Dual AD7528 attenuation sequencer: four 8-bit slots, round-robin service of
// dirty slots, serialized MSB-first on datadac/clkdac and latched by a cs strobe.
module ad7528_atten_sequencer #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [1:0] wr_slot,
  input  logic [7:0] wr_data,
  output logic       datadac,
  output logic       clkdac,
  output logic       csdac1n,
  output logic       csdac2n,
  output logic       busy,
  output logic [3:0] pending,
  output logic       done,
  output logic [1:0] done_slot
);

  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, SELECT, STROBE, HOLD} state_t;

  localparam logic [7:0] PHASE_LAST    = 8'(CLKDIV - 1);
  localparam logic [7:0] PHASE_PRELAST = 8'(CLKDIV - 2);

  state_t     state_reg;
  logic [7:0] vals_reg [4];
  logic [3:0] pending_reg;
  logic [3:0] pending_next;
  logic [1:0] rr_reg;
  logic [1:0] cur_slot_reg;
  logic [1:0] pick;
  logic [1:0] cand;
  logic [7:0] shift_reg;
  logic [7:0] phase_reg;
  logic [2:0] bit_idx_reg;
  logic       capture;

  // Walk downward so the pending slot closest to rr is the one kept.
  always_comb begin
    pick = rr_reg;
    cand = rr_reg;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_reg + 2'(k);
      if (pending_reg[cand]) pick = cand;
    end
  end

  assign capture = (state_reg == IDLE) && (pending_reg != 4'b0000);

  // A write in the capture cycle keeps the slot dirty so the new value follows.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pending
      assign pending_next[gi] = (wr_en && (wr_slot == 2'(gi))) ? 1'b1 :
                                (capture && (pick == 2'(gi)))  ? 1'b0 :
                                pending_reg[gi];
    end
  endgenerate

  assign pending = pending_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      for (int i = 0; i < 4; i++) vals_reg[i] <= 8'h00;
      pending_reg  <= 4'b0000;
      rr_reg       <= 2'd0;
      cur_slot_reg <= 2'd0;
      shift_reg    <= 8'h00;
      phase_reg    <= 8'h00;
      bit_idx_reg  <= 3'd0;
      datadac      <= 1'b0;
      clkdac       <= 1'b0;
      csdac1n      <= 1'b1;
      csdac2n      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_slot    <= 2'd0;
    end else begin
      pending_reg <= pending_next;
      if (wr_en) vals_reg[wr_slot] <= wr_data;
      done <= 1'b0;

      if (state_reg == IDLE) begin
        if (capture) begin
          shift_reg    <= vals_reg[pick];
          cur_slot_reg <= pick;
          rr_reg       <= pick + 2'd1;
          datadac      <= vals_reg[pick][7];
          clkdac       <= 1'b0;
          bit_idx_reg  <= 3'd7;
          phase_reg    <= 8'h00;
          busy         <= 1'b1;
          state_reg    <= BIT_LO;
        end
      end else if (phase_reg != PHASE_LAST) begin
        phase_reg <= phase_reg + 8'd1;
        // done is registered, so raise it on entry to the final HOLD cycle.
        if (state_reg == HOLD && phase_reg == PHASE_PRELAST) begin
          done      <= 1'b1;
          done_slot <= cur_slot_reg;
        end
      end else begin
        phase_reg <= 8'h00;
        case (state_reg)
          BIT_LO: begin
            clkdac    <= 1'b1;
            state_reg <= BIT_HI;
          end
          BIT_HI: begin
            clkdac <= 1'b0;
            if (bit_idx_reg == 3'd0) begin
              datadac   <= ~cur_slot_reg[0];
              state_reg <= SELECT;
            end else begin
              bit_idx_reg <= bit_idx_reg - 3'd1;
              datadac     <= shift_reg[bit_idx_reg - 3'd1];
              state_reg   <= BIT_LO;
            end
          end
          SELECT: begin
            csdac1n   <= cur_slot_reg[1];
            csdac2n   <= ~cur_slot_reg[1];
            state_reg <= STROBE;
          end
          STROBE: begin
            csdac1n   <= 1'b1;
            csdac2n   <= 1'b1;
            state_reg <= HOLD;
            if (CLKDIV == 1) begin
              done      <= 1'b1;
              done_slot <= cur_slot_reg;
            end
          end
          HOLD: begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad7528_atten_sequencer.sv
// Directed bench for ad7528_atten_sequencer: a 74HC164+latch model rebuilt from
// the DAC pins, with a queue of expected transfers popped on every done pulse.
module tb_ad7528_atten_sequencer;

  localparam int CLKDIV = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_slot = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       datadac, clkdac, csdac1n, csdac2n, busy, done;
  logic [3:0] pending;
  logic [1:0] done_slot;

  ad7528_atten_sequencer #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .datadac(datadac), .clkdac(clkdac), .csdac1n(csdac1n), .csdac2n(csdac2n),
    .busy(busy), .pending(pending), .done(done), .done_slot(done_slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] slot;
    logic [7:0] val;
  } xfer_t;

  xfer_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Pin-level DAC model state
  logic [7:0] sr = 8'h00;
  logic [7:0] lat [4] = '{default: 8'h00};
  logic [1:0] lat_slot = 2'd0;
  logic [7:0] lat_val = 8'h00;
  logic prev_clkdac = 1'b0, prev_cs1 = 1'b1, prev_cs2 = 1'b1, prev_datadac = 1'b0;
  bit   viol = 1'b0;
  int rises = 0, cs_falls = 0, busy_cyc = 0, ndone = 0;
  int rise_mark = 0, fall_mark = 0, busy_mark = 0;

  function automatic xfer_t mk(input logic [1:0] s, input logic [7:0] v);
    xfer_t x;
    x.slot = s;
    x.val  = v;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic mark_sync();
    rise_mark = rises;
    fall_mark = cs_falls;
    busy_mark = busy_cyc;
    viol      = 1'b0;
  endtask

  task automatic tick();
    xfer_t e;
    @(negedge clk);
    if (busy) busy_cyc++;
    if (!prev_clkdac && clkdac) begin
      sr = {sr[6:0], datadac};
      rises++;
    end
    if (prev_cs1 && !csdac1n) begin
      lat_slot = datadac ? 2'd0 : 2'd1;
      lat_val  = sr;
      lat[lat_slot] = sr;
      cs_falls++;
    end
    if (prev_cs2 && !csdac2n) begin
      lat_slot = datadac ? 2'd2 : 2'd3;
      lat_val  = sr;
      lat[lat_slot] = sr;
      cs_falls++;
    end
    if (!csdac1n && !csdac2n) viol = 1'b1;
    if (datadac !== prev_datadac &&
        ((prev_clkdac && clkdac) || !csdac1n || !csdac2n || !prev_cs1 || !prev_cs2))
      viol = 1'b1;
    if (done) begin
      ndone++;
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("xfer done_slot=%0d latched_slot=%0d latched=%02h expect_slot=%0d expect=%02h",
                 done_slot, lat_slot, lat_val, e.slot, e.val);
        chk("done_slot", 32'(done_slot), 32'(e.slot));
        chk("latch_slot", 32'(lat_slot), 32'(e.slot));
        chk("latch_value", 32'(lat_val), 32'(e.val));
        chk("clkdac_rises", 32'(rises - rise_mark), 32'd8);
        chk("cs_falls", 32'(cs_falls - fall_mark), 32'd1);
        chk("busy_cycles", 32'(busy_cyc - busy_mark), 32'(19 * CLKDIV));
        chk("pin_rules", 32'(viol), 32'd0);
      end
      mark_sync();
    end
    prev_clkdac  = clkdac;
    prev_cs1     = csdac1n;
    prev_cs2     = csdac2n;
    prev_datadac = datadac;
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] v);
    wr_en   = 1'b1;
    wr_slot = s;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    chk("idle_within_budget", 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  initial begin
    int n;
    int target;
    logic [7:0] saved;

    // Reset values
    tick();
    tick();
    chk("rst_datadac", 32'(datadac), 32'd0);
    chk("rst_clkdac", 32'(clkdac), 32'd0);
    chk("rst_cs", 32'({csdac1n, csdac2n}), 32'b11);
    chk("rst_busy_done", 32'({busy, done, done_slot}), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    resetn = 1'b1;
    mark_sync();
    repeat (1000) tick();
    chk("idle_rises", 32'(rises - rise_mark), 32'd0);
    chk("idle_cs_falls", 32'(cs_falls - fall_mark), 32'd0);
    chk("idle_busy", 32'(busy_cyc - busy_mark), 32'd0);
    mark_sync();

    // Single transfer, write-to-datadac latency of two edges
    exp_q.push_back(mk(2'd0, 8'hA5));
    wr(2'd0, 8'hA5);
    chk("lat1_pending", 32'(pending), 32'b0001);
    chk("lat1_busy", 32'(busy), 32'd0);
    tick();
    chk("lat2_busy", 32'(busy), 32'd1);
    chk("lat2_datadac", 32'(datadac), 32'd1);
    chk("lat2_clkdac", 32'(clkdac), 32'd0);
    chk("lat2_pending", 32'(pending), 32'd0);
    wait_idle(200);
    chk("model_left_a", 32'(lat[0]), 32'hA5);

    // All four dirty while slot 3 is in flight; rr wraps to 0 -> 0,1,2,3
    exp_q.push_back(mk(2'd3, 8'h3C));
    wr(2'd3, 8'h3C);
    tick();
    exp_q.push_back(mk(2'd0, 8'h0F));
    exp_q.push_back(mk(2'd1, 8'h5A));
    exp_q.push_back(mk(2'd2, 8'h96));
    exp_q.push_back(mk(2'd3, 8'hC3));
    wr(2'd3, 8'hC3);
    wr(2'd1, 8'h5A);
    wr(2'd2, 8'h96);
    wr(2'd0, 8'h0F);
    chk("rr0_pending", 32'(pending), 32'b1111);
    wait_idle(1000);
    chk("model_all", 32'({lat[0], lat[1], lat[2], lat[3]}), 32'h0F5A96C3);

    // Serving slot 1 leaves rr=2, so slot 2 beats slot 0
    exp_q.push_back(mk(2'd1, 8'h11));
    wr(2'd1, 8'h11);
    tick();
    exp_q.push_back(mk(2'd2, 8'h02));
    exp_q.push_back(mk(2'd0, 8'h01));
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h02);
    wait_idle(1000);
    chk("model_rr2", 32'({lat[0], lat[1], lat[2], lat[3]}), 32'h011102C3);

    // Rewrite of a pending slot before service: one transfer of the newest value
    exp_q.push_back(mk(2'd3, 8'h7E));
    wr(2'd3, 8'h7E);
    tick();
    exp_q.push_back(mk(2'd2, 8'h20));
    wr(2'd2, 8'h10);
    wr(2'd2, 8'h20);
    wait_idle(1000);
    chk("model_right_a", 32'(lat[2]), 32'h20);

    // Write in the capture cycle: old value goes out, new value follows
    exp_q.push_back(mk(2'd0, 8'h77));
    exp_q.push_back(mk(2'd0, 8'h88));
    wr(2'd0, 8'h77);
    wr(2'd0, 8'h88);
    chk("capwr_pending", 32'(pending), 32'b0001);
    chk("capwr_busy", 32'(busy), 32'd1);
    wait_idle(1000);
    chk("model_capwr", 32'(lat[0]), 32'h88);

    // Write to the in-flight slot after capture
    exp_q.push_back(mk(2'd1, 8'h33));
    wr(2'd1, 8'h33);
    tick();
    exp_q.push_back(mk(2'd1, 8'h44));
    wr(2'd1, 8'h44);
    chk("inflight_pending", 32'(pending), 32'b0010);
    target = ndone + 1;
    n = 0;
    while (ndone < target && n < 200) begin
      tick();
      n++;
    end
    chk("inflight_first_done", 32'(ndone >= target), 32'd1);
    chk("inflight_pending_at_done", 32'(pending), 32'b0010);
    chk("inflight_first_latch", 32'(lat[1]), 32'h33);
    wait_idle(1000);
    chk("inflight_pending_end", 32'(pending), 32'd0);
    chk("inflight_second_latch", 32'(lat[1]), 32'h44);

    // Asynchronous reset during BIT_HI aborts with no latch
    saved = lat[0];
    wr(2'd0, 8'hEE);
    n = 0;
    while (!clkdac && n < 20) begin
      tick();
      n++;
    end
    chk("abort_reached_bit_hi", 32'(clkdac), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_clkdac", 32'(clkdac), 32'd0);
    chk("abort_cs", 32'({csdac1n, csdac2n}), 32'b11);
    chk("abort_pending", 32'(pending), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (50) tick();
    chk("abort_no_latch", 32'(cs_falls - fall_mark), 32'd0);
    chk("abort_model_left_a", 32'(lat[0]), 32'(saved));
    mark_sync();

    // Recovery after abort
    exp_q.push_back(mk(2'd2, 8'hC9));
    wr(2'd2, 8'hC9);
    wait_idle(200);
    chk("recover_right_a", 32'(lat[2]), 32'hC9);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
